// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl_pkg -- shared definitions for the SISC control unit.
// Holds the FSM state encoding, opcode constants, the immediate addressing
// mode value and the alu_op encodings used by sisc_ctrl_gen and sisc_br_cond.
package sisc_ctrl_pkg;

    typedef enum logic [2:0] {
        StStart     = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6
    } state_e;

    localparam logic [3:0] OpNoop = 4'd0;
    localparam logic [3:0] OpLod  = 4'd1;
    localparam logic [3:0] OpStr  = 4'd2;
    localparam logic [3:0] OpBra  = 4'd4;
    localparam logic [3:0] OpBrr  = 4'd5;
    localparam logic [3:0] OpBne  = 4'd6;
    localparam logic [3:0] OpBnr  = 4'd7;
    localparam logic [3:0] OpAlu  = 4'd8;
    localparam logic [3:0] OpHlt  = 4'd15;

    // mm value selecting the immediate addressing mode
    localparam logic [3:0] AmImm = 4'd8;

    localparam logic [1:0] AluRegReg  = 2'b00;
    localparam logic [1:0] AluImm     = 2'b01;
    localparam logic [1:0] AluRegAddr = 2'b10;
    localparam logic [1:0] AluImmAddr = 2'b11;

    // alu_op for an instruction in EXECUTE..WRITEBACK
    function automatic logic [1:0] alu_op_of(logic [3:0] op, logic [3:0] mode);
        if (op == OpAlu) begin
            return (mode == AmImm) ? AluImm : AluRegReg;
        end else if (op == OpLod || op == OpStr) begin
            return (mode == AmImm) ? AluImmAddr : AluRegAddr;
        end
        return AluRegReg;
    endfunction

endpackage

// File: rtl/sisc_ctrl_gen_if.sv
// sisc_ctrl_gen_if -- bundle between the SISC controller and its datapath.
// Inputs to the controller: opcode, mm, stat, mem_ready.
// Outputs from the controller: rf_we, dm_we, alu_op, wb_sel, rb_sel, pc_sel,
// pc_write, pc_rst, ir_load, br_sel, halted, state, icount.
// master = controller side, slave = datapath side.
interface sisc_ctrl_gen_if
    import sisc_ctrl_pkg::*;
#(
    parameter int unsigned OPW  = 4,
    parameter int unsigned CCW  = 4,
    parameter int unsigned CNTW = 16
);
    logic [OPW-1:0]  opcode;
    logic [CCW-1:0]  mm;
    logic [CCW-1:0]  stat;
    logic            mem_ready;
    logic            rf_we;
    logic            dm_we;
    logic [1:0]      alu_op;
    logic            wb_sel;
    logic            rb_sel;
    logic            pc_sel;
    logic            pc_write;
    logic            pc_rst;
    logic            ir_load;
    logic            br_sel;
    logic            halted;
    state_e          state;
    logic [CNTW-1:0] icount;

    modport master (
        input  opcode, mm, stat, mem_ready,
        output rf_we, dm_we, alu_op, wb_sel, rb_sel, pc_sel, pc_write, pc_rst,
               ir_load, br_sel, halted, state, icount
    );

    modport slave (
        output opcode, mm, stat, mem_ready,
        input  rf_we, dm_we, alu_op, wb_sel, rb_sel, pc_sel, pc_write, pc_rst,
               ir_load, br_sel, halted, state, icount
    );
endinterface

// File: rtl/sisc_br_cond.sv
// sisc_br_cond -- branch condition evaluation.
// Ports: opcode, stat, mm (in); taken (branch condition met), br_sel
// (1 = absolute target for BRA/BNE) (out). Non-branch opcodes give 0/0.
module sisc_br_cond
    import sisc_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 4,
    parameter int unsigned CCW = 4
) (
    input  logic [OPW-1:0] opcode,
    input  logic [CCW-1:0] stat,
    input  logic [CCW-1:0] mm,
    output logic           taken,
    output logic           br_sel
);
    logic hit;
    assign hit = |(stat & mm);

    always_comb begin
        taken  = 1'b0;
        br_sel = 1'b0;
        case (opcode)
            OpBra: begin taken = hit;  br_sel = 1'b1; end
            OpBrr: begin taken = hit;                 end
            OpBne: begin taken = ~hit; br_sel = 1'b1; end
            OpBnr: begin taken = ~hit;                end
            default: ;
        endcase
    end
endmodule

// File: rtl/sisc_ctrl_gen.sv
// sisc_ctrl_gen -- multi-cycle control FSM for the SISC processor.
// Ports: clk, rst_f (async, active-low), bus (sisc_ctrl_gen_if.master):
// instruction/status inputs in, datapath enables, debug state and the
// retired-instruction counter out.
// Build option: define SISC_CTRL_MEM_WAIT_EN to stretch MEM until mem_ready;
// otherwise mem_ready is ignored and MEM is a single cycle.
module sisc_ctrl_gen
    import sisc_ctrl_pkg::*;
#(
    parameter int unsigned OPW  = 4,
    parameter int unsigned CCW  = 4,
    parameter int unsigned CNTW = 16
) (
    input logic             clk,
    input logic             rst_f,
    sisc_ctrl_gen_if.master bus
);
    state_e          state_q, state_d;
    logic [CNTW-1:0] icount_q;
    logic            taken, br_abs;
    logic            op_lod, op_str, op_alu, op_hlt, mem_done, retire;
    logic [1:0]      exec_alu_op;

    sisc_br_cond #(
        .OPW (OPW),
        .CCW (CCW)
    ) u_br_cond (
        .opcode (bus.opcode),
        .stat   (bus.stat),
        .mm     (bus.mm),
        .taken  (taken),
        .br_sel (br_abs)
    );

    assign op_lod      = (bus.opcode == OpLod);
    assign op_str      = (bus.opcode == OpStr);
    assign op_alu      = (bus.opcode == OpAlu);
    assign op_hlt      = (bus.opcode == OpHlt);
    assign exec_alu_op = alu_op_of(bus.opcode, bus.mm);

`ifdef SISC_CTRL_MEM_WAIT_EN
    assign mem_done = bus.mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStart:  state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (op_hlt)                           state_d = StHalt;
                else if (op_lod || op_str || op_alu)  state_d = StExecute;
                else                                  state_d = StFetch;
            end
            StExecute: begin
                if (op_lod || op_str) state_d = StMem;
                else if (op_alu)      state_d = StWriteback;
                else                  state_d = StFetch;
            end
            StMem: begin
                if (mem_done) state_d = op_lod ? StWriteback : StFetch;
            end
            StWriteback: state_d = StFetch;
            StHalt:      state_d = StHalt;
            default:     state_d = StStart;
        endcase
    end

    // An instruction retires when control returns to FETCH from any later state
    assign retire = (state_d == StFetch) &&
                    (state_q == StDecode || state_q == StMem || state_q == StWriteback);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q  <= StStart;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            if (retire) icount_q <= icount_q + 1'b1;
        end
    end

    // Outputs decode only the registered state, never state_d
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.dm_we    = 1'b0;
        bus.alu_op   = AluRegReg;
        bus.wb_sel   = 1'b0;
        bus.rb_sel   = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.br_sel   = 1'b0;
        bus.halted   = 1'b0;
        unique case (state_q)
            StStart: bus.pc_rst = 1'b1;
            StFetch: begin
                bus.pc_write = 1'b1;
                bus.ir_load  = 1'b1;
            end
            StDecode: begin
                bus.pc_write = taken;
                bus.pc_sel   = taken;
                bus.br_sel   = br_abs;
                bus.rb_sel   = op_str;
            end
            StExecute: begin
                bus.alu_op = exec_alu_op;
                bus.rb_sel = op_str;
            end
            StMem: begin
                bus.alu_op = exec_alu_op;
                bus.rb_sel = op_str;
                bus.dm_we  = op_str;
                bus.wb_sel = op_lod;
            end
            StWriteback: begin
                bus.alu_op = exec_alu_op;
                bus.wb_sel = op_lod;
                bus.rf_we  = op_alu || op_lod;
            end
            StHalt:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state  = state_q;
    assign bus.icount = icount_q;
endmodule

// File: tb/tb_sisc_ctrl_gen.sv
// tb_sisc_ctrl_gen -- self-checking bench for sisc_ctrl_gen (default build and
// with SISC_CTRL_MEM_WAIT_EN). Expected outputs come from a per-instruction
// phase list built from the instruction rules.
module tb_sisc_ctrl_gen;
    import sisc_ctrl_pkg::*;

    // Phase codes follow the listed state order START..HALT
    localparam int PhStart = 0, PhFetch = 1, PhDecode = 2, PhExec = 3;
    localparam int PhMem = 4, PhWb = 5, PhHalt = 6;

    logic clk = 1'b0;
    logic rst_f;
    logic rst4;
    always #5 clk = ~clk;

    sisc_ctrl_gen_if #(.OPW(4), .CCW(4), .CNTW(16)) bus ();
    sisc_ctrl_gen_if #(.OPW(4), .CCW(4), .CNTW(4))  bus4 ();

    sisc_ctrl_gen #(.OPW(4), .CCW(4), .CNTW(16)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    sisc_ctrl_gen #(.OPW(4), .CCW(4), .CNTW(4)) dut4 (
        .clk   (clk),
        .rst_f (rst4),
        .bus   (bus4)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cnt         = 0;

    function automatic logic [30:0] exp_vec(int ph, int op, int mm, int stat, int unsigned c);
        logic       rf, dm, wb, rb, ps, pw, pr, il, bs, h;
        logic [1:0] ao;
        bit         tk, isalu, islod, isstr;
        tk    = ((op == 4 || op == 5) && (stat & mm) != 0) ||
                ((op == 6 || op == 7) && (stat & mm) == 0);
        isalu = (op == 8);
        islod = (op == 1);
        isstr = (op == 2);
        {rf, dm, wb, rb, ps, pw, pr, il, bs, h} = '0;
        ao = 2'd0;
        if (ph >= PhExec && ph <= PhWb) begin
            if (isalu)               ao = (mm == 8) ? 2'd1 : 2'd0;
            else if (islod || isstr) ao = (mm == 8) ? 2'd3 : 2'd2;
        end
        case (ph)
            PhStart:  pr = 1'b1;
            PhFetch:  begin pw = 1'b1; il = 1'b1; end
            PhDecode: begin pw = tk; ps = tk; bs = (op == 4 || op == 6); rb = isstr; end
            PhExec:   rb = isstr;
            PhMem:    begin rb = isstr; dm = isstr; wb = islod; end
            PhWb:     begin wb = islod; rf = isalu || islod; end
            PhHalt:   h = 1'b1;
            default: ;
        endcase
        return {3'(ph), rf, dm, ao, wb, rb, ps, pw, pr, il, bs, h, 16'(c)};
    endfunction

    task automatic check(input string tag, input logic [30:0] exp);
        logic [30:0] obs;
        obs = {bus.state, bus.rf_we, bus.dm_we, bus.alu_op, bus.wb_sel, bus.rb_sel,
               bus.pc_sel, bus.pc_write, bus.pc_rst, bus.ir_load, bus.br_sel, bus.halted,
               bus.icount};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting at the edge that enters FETCH.
    // w = number of MEM cycles with mem_ready held low.
    task automatic run_instr(input int op, input int mm, input int stat, input int w);
        int ph[$];
        int mem_n;
        int mk;
`ifdef SISC_CTRL_MEM_WAIT_EN
        mem_n = w + 1;
`else
        mem_n = 1;
`endif
        ph = '{PhFetch, PhDecode};
        if (op == 15) begin
            ph.push_back(PhHalt);
        end else if (op == 8) begin
            ph.push_back(PhExec);
            ph.push_back(PhWb);
        end else if (op == 1 || op == 2) begin
            ph.push_back(PhExec);
            for (int k = 0; k < mem_n; k++) ph.push_back(PhMem);
            if (op == 1) ph.push_back(PhWb);
        end
        mk = 0;
        foreach (ph[i]) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                bus.opcode = 4'(op);
                bus.mm     = 4'(mm);
                bus.stat   = 4'(stat);
            end
            if (ph[i] == PhMem) begin
                bus.mem_ready = (mk >= w);
                mk++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1 check($sformatf("op%0d_mm%0d_st%0d_ph%0d", op, mm, stat, ph[i]),
                     exp_vec(ph[i], op, mm, stat, cnt));
        end
        if (op != 15) cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, mm, st, w;
        logic [3:0] ic4;
        rst_f = 1'b0;
        rst4  = 1'b0;
        bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.mem_ready = 1'b1;
        bus4.opcode = '0; bus4.mm = '0; bus4.stat = '0; bus4.mem_ready = 1'b1;

        // Reset holds START regardless of clock edges
        #3 check("reset", exp_vec(PhStart, 0, 0, 0, 0));
        #20 check("reset_hold", exp_vec(PhStart, 0, 0, 0, 0));
        @(negedge clk);
        rst_f = 1'b1;

        // Directed: ALU immediate, branches taken / not taken, LOD with wait, STR
        run_instr(8, 8, 0, 0);
        run_instr(4, 2, 2, 0);
        run_instr(4, 2, 4, 0);
        run_instr(6, 3, 0, 0);
        run_instr(7, 3, 1, 0);
        run_instr(5, 15, 8, 0);
        run_instr(1, 0, 0, 3);
        run_instr(2, 8, 5, 2);
        run_instr(3, 0, 0, 0);
        run_instr(0, 0, 0, 0);

        // Random instruction stream (HLT excluded)
        repeat (60) begin
            op = $urandom_range(0, 14);
            mm = ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 15);
            st = $urandom_range(0, 15);
            w  = $urandom_range(0, 3);
            run_instr(op, mm, st, w);
        end

        // Reset during EXECUTE of STR: abort, no dm_we, FETCH after release
        @(posedge clk); #1;
        bus.opcode = 4'd2; bus.mm = 4'd0; bus.stat = 4'd0; bus.mem_ready = 1'b1;
        #1 check("abort_fetch", exp_vec(PhFetch, 2, 0, 0, cnt));
        @(posedge clk); #2 check("abort_decode", exp_vec(PhDecode, 2, 0, 0, cnt));
        @(posedge clk); #2 check("abort_exec", exp_vec(PhExec, 2, 0, 0, cnt));
        #1 rst_f = 1'b0;
        cnt = 0;
        #1 check("abort_reset", exp_vec(PhStart, 0, 0, 0, 0));
        repeat (3) begin
            @(posedge clk);
            #1 check("abort_hold", exp_vec(PhStart, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_f = 1'b1;
        run_instr(0, 0, 0, 0);
        run_instr(8, 1, 0, 0);

        // HLT: sticky, opcode changes ignored
        run_instr(15, 0, 0, 0);
        repeat (100) begin
            @(posedge clk); #1;
            bus.opcode = 4'($urandom);
            bus.mm     = 4'($urandom);
            bus.stat   = 4'($urandom);
            #1 check("halt", exp_vec(PhHalt, 0, 0, 0, cnt));
        end

        // CNTW = 4 with NOOPs: k-th retirement lands at edge 2k+1 after release
        @(negedge clk);
        rst4 = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #2;
            ic4 = 4'((e - 1) / 2);
            vectors++;
            assert (bus4.icount === ic4) else begin
                miscompares++;
                $error("FAIL icount_wrap_e%0d: observed %h expected %h", e, bus4.icount, ic4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
